// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO, any DEPTH >= 2, standard or FWFT output,
//               occupancy count, almost-full/empty flags, flush, error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH         = 16,
    parameter int DEPTH         = 16,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_shift,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_full,
    output logic                       in_afull,
    input  logic                       out_pop,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_nempty,
    output logic                       out_aempty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int              c_pw     = $clog2(DEPTH);
    localparam int              c_cw     = $clog2(DEPTH + 1);
    localparam logic [c_pw-1:0] c_last   = c_pw'(DEPTH - 1);
    localparam logic [c_cw-1:0] c_depth  = c_cw'(DEPTH);
    localparam logic [c_cw-1:0] c_afull  = c_cw'(AFULL_THRESH);
    localparam logic [c_cw-1:0] c_aempty = c_cw'(AEMPTY_THRESH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_pw-1:0]  r_wr_pos;
    logic [c_pw-1:0]  r_rd_pos;
    logic [c_cw-1:0]  r_count;
    logic             r_full;
    logic             r_afull;
    logic             r_nempty;
    logic             r_aempty;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic [c_cw-1:0]  w_count_next;
    logic [c_pw-1:0]  w_wr_pos_next;
    logic [c_pw-1:0]  w_rd_pos_next;

    // Acceptance looks only at the flags registered at the start of the cycle
    assign w_push_ok     = in_shift & ~r_full & ~flush;
    assign w_pop_ok      = out_pop & r_nempty & ~flush;
    assign w_count_next  = r_count + c_cw'(w_push_ok) - c_cw'(w_pop_ok);
    assign w_wr_pos_next = (r_wr_pos == c_last) ? '0 : r_wr_pos + 1'b1;
    assign w_rd_pos_next = (r_rd_pos == c_last) ? '0 : r_rd_pos + 1'b1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_pos    <= '0;
            r_rd_pos    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_afull     <= 1'b0;
            r_nempty    <= 1'b0;
            r_aempty    <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_pos    <= '0;
            r_rd_pos    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_afull     <= 1'b0;
            r_nempty    <= 1'b0;
            r_aempty    <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_pos <= w_wr_pos_next;
            if (w_pop_ok)  r_rd_pos <= w_rd_pos_next;
            r_count  <= w_count_next;
            r_full   <= (w_count_next == c_depth);
            r_afull  <= (w_count_next >= c_afull);
            r_nempty <= (w_count_next != '0);
            r_aempty <= (w_count_next <= c_aempty);
            if (in_shift & r_full)   r_overflow  <= 1'b1;
            if (out_pop & ~r_nempty) r_underflow <= 1'b1;
        end
    end

    // Storage has no reset; flush and reset only move the pointers
    always_ff @(posedge clock) begin
        if (reset_n && w_push_ok) r_mem[r_wr_pos] <= in_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign out_data = r_mem[r_rd_pos];
        end else begin : g_std
            logic [WIDTH-1:0] r_out_data;
            always_ff @(posedge clock) begin
                if (!reset_n)      r_out_data <= '0;
                else if (w_pop_ok) r_out_data <= r_mem[r_rd_pos];
            end
            assign out_data = r_out_data;
        end
    endgenerate

    assign in_full    = r_full;
    assign in_afull   = r_afull;
    assign out_nempty = r_nempty;
    assign out_aempty = r_aempty;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo
// Description : Bench for sync_fifo: 16-deep standard-output and 5-deep FWFT
//               instances against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        a_rst_n, a_flush, a_shift, a_pop;
    logic [15:0] a_din, a_dout;
    logic        a_full, a_afull, a_nempty, a_aempty, a_ovf, a_udf;
    logic [4:0]  a_count;

    logic        b_rst_n, b_flush, b_shift, b_pop;
    logic [15:0] b_din, b_dout;
    logic        b_full, b_afull, b_nempty, b_aempty, b_ovf, b_udf;
    logic [2:0]  b_count;

    sync_fifo #(.WIDTH(16), .DEPTH(16), .FWFT(0), .AFULL_THRESH(12), .AEMPTY_THRESH(4)) u_a (
        .clock(clk), .reset_n(a_rst_n), .flush(a_flush), .in_shift(a_shift), .in_data(a_din),
        .in_full(a_full), .in_afull(a_afull), .out_pop(a_pop), .out_data(a_dout),
        .out_nempty(a_nempty), .out_aempty(a_aempty), .count(a_count),
        .overflow(a_ovf), .underflow(a_udf));

    sync_fifo #(.WIDTH(16), .DEPTH(5), .FWFT(1), .AFULL_THRESH(4), .AEMPTY_THRESH(1)) u_b (
        .clock(clk), .reset_n(b_rst_n), .flush(b_flush), .in_shift(b_shift), .in_data(b_din),
        .in_full(b_full), .in_afull(b_afull), .out_pop(b_pop), .out_data(b_dout),
        .out_nempty(b_nempty), .out_aempty(b_aempty), .count(b_count),
        .overflow(b_ovf), .underflow(b_udf));

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic        ma_ovf, ma_udf, mb_ovf, mb_udf;
    logic [15:0] ma_od, mb_od;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a FIFO is a queue; acceptance uses the occupancy before the edge
    task automatic mstep(inout logic [15:0] q[$], inout logic ovf, inout logic udf,
                         inout logic [15:0] od, input int depth, input logic rn,
                         input logic fl, input logic sh, input logic pp, input logic [15:0] din);
        int n = q.size();
        if (!rn) begin
            q.delete(); ovf = 1'b0; udf = 1'b0; od = '0;
        end else if (fl) begin
            q.delete(); ovf = 1'b0; udf = 1'b0;
        end else begin
            if (sh && n == depth) ovf = 1'b1;
            if (pp && n == 0)     udf = 1'b1;
            if (pp && n > 0)      od = q.pop_front();
            if (sh && n < depth)  q.push_back(din);
        end
    endtask

    task automatic check_fifo(input string nm, input logic [15:0] q[$], input int depth,
                              input bit fwft, input int afth, input int aeth,
                              input logic movf, input logic mudf, input logic [15:0] mod,
                              input logic [31:0] cnt, input logic full, input logic afull,
                              input logic nempty, input logic aempty, input logic ovf,
                              input logic udf, input logic [15:0] dout);
        int n = q.size();
        check({nm, "_count"},     cnt,    n);
        check({nm, "_full"},      full,   n == depth);
        check({nm, "_afull"},     afull,  n >= afth);
        check({nm, "_nempty"},    nempty, n != 0);
        check({nm, "_aempty"},    aempty, n <= aeth);
        check({nm, "_overflow"},  ovf,    movf);
        check({nm, "_underflow"}, udf,    mudf);
        if (!fwft)     check({nm, "_out_data"}, dout, mod);
        else if (n > 0) check({nm, "_fwft_data"}, dout, q[0]);
    endtask

    task automatic cycle();
        @(posedge clk);
        mstep(qa, ma_ovf, ma_udf, ma_od, 16, a_rst_n, a_flush, a_shift, a_pop, a_din);
        mstep(qb, mb_ovf, mb_udf, mb_od, 5, b_rst_n, b_flush, b_shift, b_pop, b_din);
        @(negedge clk);
        check_fifo("A", qa, 16, 1'b0, 12, 4, ma_ovf, ma_udf, ma_od, {27'b0, a_count},
                   a_full, a_afull, a_nempty, a_aempty, a_ovf, a_udf, a_dout);
        check_fifo("B", qb, 5, 1'b1, 4, 1, mb_ovf, mb_udf, mb_od, {29'b0, b_count},
                   b_full, b_afull, b_nempty, b_aempty, b_ovf, b_udf, b_dout);
    endtask

    task automatic idle();
        a_rst_n = 1'b1; a_flush = 1'b0; a_shift = 1'b0; a_pop = 1'b0;
        b_rst_n = 1'b1; b_flush = 1'b0; b_shift = 1'b0; b_pop = 1'b0;
    endtask

    initial begin
        idle();
        a_din = '0; b_din = '0;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        cycle(); cycle();
        check("rst_count",  {27'b0, a_count}, 32'd0);
        check("rst_aempty", a_aempty, 1'b1);
        check("rst_dout",   a_dout, 16'h0000);
        idle();

        // Fill 16-deep FIFO with 1..16
        for (int i = 1; i <= 16; i++) begin
            a_shift = 1'b1; a_din = 16'(i);
            cycle();
            if (i == 11) check("afull_before_12", a_afull, 1'b0);
            if (i == 12) check("afull_at_12", a_afull, 1'b1);
        end
        check("full_at_16",  a_full, 1'b1);
        check("count_at_16", {27'b0, a_count}, 32'd16);
        a_din = 16'h0011;
        cycle();
        check("overflow_17th", a_ovf, 1'b1);
        check("count_hold_16", {27'b0, a_count}, 32'd16);
        a_shift = 1'b0;

        // Drain: data in order, one cycle after each pop
        for (int i = 1; i <= 16; i++) begin
            a_pop = 1'b1;
            cycle();
            check("pop_order", a_dout, 16'(i));
            if (i == 11) check("aempty_at_5", a_aempty, 1'b0);
            if (i == 12) check("aempty_at_4", a_aempty, 1'b1);
        end
        cycle();
        check("underflow_17th", a_udf, 1'b1);
        check("dout_hold",      a_dout, 16'h0010);
        a_pop = 1'b0;

        // Simultaneous push and pop at full
        a_flush = 1'b1; cycle(); a_flush = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a_shift = 1'b1; a_din = 16'($urandom_range(0, 65535)); cycle();
        end
        a_pop = 1'b1; a_din = 16'hAAAA;
        cycle();
        check("full_pp_count", {27'b0, a_count}, 32'd15);
        check("full_pp_ovf",   a_ovf, 1'b1);

        // Flush with push and pop at count 7, overflow set
        a_shift = 1'b0;
        repeat (8) cycle();
        check("count_7", {27'b0, a_count}, 32'd7);
        a_flush = 1'b1; a_shift = 1'b1; a_pop = 1'b1; a_din = 16'hDEAD;
        cycle();
        idle();
        check("flush_count",  {27'b0, a_count}, 32'd0);
        check("flush_nempty", a_nempty, 1'b0);
        check("flush_aempty", a_aempty, 1'b1);
        check("flush_ovf",    a_ovf, 1'b0);
        a_shift = 1'b1; a_din = 16'h1234; cycle();
        a_shift = 1'b0; a_pop = 1'b1; cycle();
        check("post_flush_word", a_dout, 16'h1234);
        a_pop = 1'b0;

        // Reset at count 9 while pushing
        for (int i = 0; i < 9; i++) begin
            a_shift = 1'b1; a_din = 16'($urandom_range(0, 65535)); cycle();
        end
        a_rst_n = 1'b0; a_din = 16'h5555;
        cycle();
        check("rst_mid_count",  {27'b0, a_count}, 32'd0);
        check("rst_mid_nempty", a_nempty, 1'b0);
        check("rst_mid_dout",   a_dout, 16'h0000);
        a_rst_n = 1'b1; a_din = 16'hBEEF; cycle();
        a_shift = 1'b0; a_pop = 1'b1; cycle();
        check("beef_first", a_dout, 16'hBEEF);
        idle();

        // FWFT, depth 5: steady-state streaming at count 3 across wraps
        for (int i = 0; i < 3; i++) begin
            b_shift = 1'b1; b_din = 16'($urandom_range(0, 65535)); cycle();
        end
        b_pop = 1'b1;
        for (int i = 0; i < 40; i++) begin
            b_din = 16'($urandom_range(0, 65535));
            cycle();
            check("stream_count", {29'b0, b_count}, 32'd3);
        end
        idle();

        // Randomised traffic on both instances
        for (int k = 0; k < 400; k++) begin
            int bias;
            bias    = ((k % 100) < 50) ? 75 : 30;
            a_rst_n = ($urandom_range(0, 99) != 0);
            b_rst_n = ($urandom_range(0, 99) != 0);
            a_flush = ($urandom_range(0, 49) == 0);
            b_flush = ($urandom_range(0, 49) == 0);
            a_shift = ($urandom_range(0, 99) < bias);
            b_shift = ($urandom_range(0, 99) < bias);
            a_pop   = ($urandom_range(0, 99) < 50);
            b_pop   = ($urandom_range(0, 99) < 50);
            a_din   = 16'($urandom_range(0, 65535));
            b_din   = 16'($urandom_range(0, 65535));
            cycle();
        end
        idle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO for buffering bus-engine data between the command decoder and the protocol shifters. Any DEPTH ≥ 2, not just powers of two. Selectable standard or first-word-fall-through output. Provides an occupancy count, almost-full and almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.

## Interface
- WIDTH, 16, data word width in bits (≥ 1)
- DEPTH, 16, number of storage entries (≥ 2, any integer)
- FWFT, 0, output mode: 0 = registered read data, 1 = first-word-fall-through
- AFULL_THRESH, 12, in_afull asserts when count ≥ this value (1..DEPTH)
- AEMPTY_THRESH, 4, out_aempty asserts when count ≤ this value (0..DEPTH-1)

- clock  in  1  sole clock; all state changes on rising edge
- reset_n  in  1  synchronous, active-low reset
- flush  in  1  synchronous empty request
- in_shift  in  1  write request
- in_data  in  WIDTH  write data
- in_full  out  1  registered, count == DEPTH
- in_afull  out  1  registered, count ≥ AFULL_THRESH
- out_pop  in  1  read request
- out_data  out  WIDTH  read data (meaning depends on FWFT)
- out_nempty  out  1  registered, count != 0
- out_aempty  out  1  registered, count ≤ AEMPTY_THRESH
- count  out  $clog2(DEPTH+1)  registered occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH × WIDTH array, write pointer wr_pos and read pointer rd_pos. Each pointer wraps from DEPTH-1 to 0 by explicit compare, not binary rollover.
- push_ok = in_shift & !in_full & !flush; the push writes in_data to memory[wr_pos] and advances wr_pos.
- pop_ok = out_pop & out_nempty & !flush; the pop advances rd_pos.
- Acceptance uses the flag values registered at the start of the cycle. When full, a push is rejected even if a pop occurs in the same cycle. When empty, a pop is rejected even if a push occurs in the same cycle.
- count_next = count + push_ok − pop_ok. A simultaneous push and pop leaves count unchanged. All four flags are recomputed from count_next and registered, so flags and count are always mutually consistent.
- FWFT=0:
  - On pop_ok, out_data registers memory[rd_pos].
  - Otherwise out_data holds its last value.
- FWFT=1:
  - out_data = memory[rd_pos] combinationally and is valid whenever out_nempty = 1.
  - pop_ok consumes the presented word; the next word appears in the following cycle.
  - When empty, out_data is don't-care.
- Flush has priority over everything else:
  - wr_pos, rd_pos and count go to 0; in_full, in_afull and out_nempty go to 0; out_aempty goes to 1.
  - overflow and underflow are cleared.
  - Memory contents are untouched. In FWFT=0, out_data is held.
- overflow sets on in_shift & in_full & !flush. underflow sets on out_pop & !out_nempty & !flush. Both hold until flush or reset.
- Reset (reset_n = 0 at an edge):
  - Pointers, count, in_full, in_afull, out_nempty, overflow and underflow go to 0.
  - out_aempty goes to 1; the FWFT=0 out_data register goes to 0.
  - Reset overrides flush and any transfer in the same cycle, including mid-burst.

## Timing
- Write-to-visibility latency is 1 cycle. A push at edge N gives out_nempty = 1 and count = 1 after edge N.
  - FWFT=1: the word is on out_data in the cycle after edge N.
  - FWFT=0: the word is on out_data in the cycle after the pop edge.
- Back-to-back push and pop at one word per cycle sustain indefinitely at any occupancy 1..DEPTH-1.
- in_full asserts in the cycle after the push that makes count = DEPTH. It deasserts in the cycle after the first pop from full.
- No combinational path exists from any input to in_full, in_afull, out_nempty, out_aempty or count.

## Test plan
- Reset, then DEPTH=16, FWFT=0: push 0x0001..0x0010 on consecutive cycles.
  - in_afull is set after the 12th push; in_full and count = 16 after the 16th.
  - A 17th push sets overflow and leaves count = 16.
- Pop all 16 words from the previous fill: out_data = 0x0001..0x0010 in order, each one cycle after its pop.
  - out_aempty sets once count ≤ 4.
  - A 17th pop sets underflow; out_data holds 0x0010.
- DEPTH=5, FWFT=1: run 40 cycles of simultaneous push and pop with count held at 3, across multiple pointer wraps.
  - Data order is preserved; count stays at 3 throughout.
- At full, assert in_shift and out_pop together.
  - The pop is accepted and the push rejected; count = DEPTH−1; overflow sets.
- At count = 7 with overflow set, assert flush together with in_shift and out_pop.
  - Next cycle: count = 0, out_nempty = 0, out_aempty = 1, overflow = 0.
  - The pushed word is not stored.
- At count = 9, pull reset_n low for one cycle while pushing.
  - All outputs return to their reset values.
  - A subsequent push of 0xBEEF is the first word popped.
